car_item_slot: RTL
==================

Name: car_item_slot

Overview:
- Per-car consumer of the question-block pickup event.
- A one-cycle collision pulse from the q-block collision logic starts an item roulette. The drawn item is held until the driver presses "use", and the item's effect is then applied for a timed interval.
- One instance per car. Clocked by the render clock, which ticks once per frame. Outputs feed car physics (boost, shield), hazard spawning (drop) and the HUD (item, state).

Parameters:
- FRAME_RATE, 60, render-clock cycles per second.
- ROULETTE_FRAMES, 90, cycles the roulette spins before the item is fixed.
- EFFECT_SECONDS, 3, duration of the boost and shield effects in seconds.
- LFSR_SEED, 8'hA5, reset value of the item LFSR. Must be nonzero.

Ports:
- i_render_clk  in  1  render clock, one tick per frame.
- i_rst_n  in  1  asynchronous active-low reset.
- i_collision  in  1  pickup pulse for this car from the q-block collision logic.
- i_use  in  1  driver "use item" button, level signal, synchronous to i_render_clk.
- o_item  out  2  item code: 0 NONE, 1 BOOST, 2 SHIELD, 3 BANANA.
- o_state  out  2  slot state: 0 EMPTY, 1 ROULETTE, 2 HOLD, 3 ACTIVE.
- o_boost  out  1  boost effect active.
- o_shield  out  1  shield effect active.
- o_drop  out  1  one-cycle pulse requesting a banana spawn at the car position.

Behaviour:
- All outputs are registered. Reset value: o_item=0, o_state=EMPTY, o_boost=0, o_shield=0, o_drop=0. The LFSR resets to LFSR_SEED; all counters and the use-edge register reset to 0.
- LFSR: 8-bit Fibonacci, free-running every cycle in all states. fb = l[7]^l[5]^l[4]^l[3]; next = {l[6:0], fb}.
- Item map from l[1:0]: 00 and 01 map to BOOST, 10 to SHIELD, 11 to BANANA.
- Use edge: use_edge = i_use & ~use_prev, where use_prev is i_use registered. Holding i_use produces exactly one edge.
- State EMPTY: o_item=0. On i_collision=1, the next cycle is ROULETTE with frame_cnt=0.
- State ROULETTE:
  - o_item shows map(current LFSR) each cycle, as an animation.
  - frame_cnt increments each cycle.
  - The state persists exactly ROULETTE_FRAMES cycles.
  - On the cycle where frame_cnt==ROULETTE_FRAMES-1, the item map(LFSR) is latched and the next state is HOLD. The held item equals the o_item value shown on the last roulette cycle.
- State HOLD: o_item = held item. On use_edge:
  - BANANA: the next cycle has o_drop=1 for exactly one cycle, state EMPTY and o_item=0.
  - BOOST or SHIELD: the next cycle is ACTIVE, with frame_cnt=0 and sec_cnt=0.
- State ACTIVE:
  - o_item = active item. o_boost or o_shield (matching the item) is high for every ACTIVE cycle.
  - frame_cnt wraps at FRAME_RATE-1, and sec_cnt increments on each wrap.
  - When sec_cnt==EFFECT_SECONDS-1 and frame_cnt==FRAME_RATE-1, the next state is EMPTY.
  - The effect output is therefore high for exactly FRAME_RATE*EFFECT_SECONDS cycles, and it deasserts in the same cycle that o_state becomes EMPTY.
- Collisions are ignored in ROULETTE, HOLD and ACTIVE; there is no queueing. If a collision and use_edge arrive together in HOLD, use_edge wins and the collision is discarded.
- Use edges are ignored in EMPTY, ROULETTE and ACTIVE. use_prev still tracks i_use in those states.
- Reset asserted mid-roulette or mid-effect clears all state immediately (asynchronous). Effect outputs drop without waiting for the timer.
- Counter widths: frame_cnt is $clog2(max(FRAME_RATE, ROULETTE_FRAMES)) bits; sec_cnt is $clog2(EFFECT_SECONDS+1) bits. No wrap beyond the terminal values.

Optional Feature:
- Macro: CAR_ITEM_FORCE_EN.
- When defined:
  - Adds ports i_force_valid (in, 1) and i_force_item (in, 2).
  - In EMPTY or HOLD, i_force_valid=1 with i_force_item!=0 moves the next cycle to HOLD with the held item = i_force_item, skipping the roulette. This is used for debug via board switches.
  - Force takes priority over collision and use_edge in the same cycle.
  - Force with i_force_item==0 is ignored.
- When undefined: these ports do not exist and behaviour is exactly as above.

Test Plan:
- Parameters FRAME_RATE=4, ROULETTE_FRAMES=5, EFFECT_SECONDS=2, LFSR_SEED=8'hA5. After reset release, one cycle later the LFSR = 8'h4A and o_state=0, o_item=0.
- Roulette: pulse i_collision in EMPTY -> o_state=1 for exactly 5 cycles, then 2. The held o_item equals the o_item shown on the 5th roulette cycle. A second collision pulse during ROULETTE leaves the timing unchanged.
- Boost: with BOOST held, raise i_use and hold it for 20 cycles -> o_state=3 and o_boost=1 for exactly 8 cycles, then o_state=0, o_item=0, o_boost=0. There is no second activation.
- Banana: with BANANA held, pulse i_use -> o_drop=1 for exactly 1 cycle, the same cycle as o_state=0. i_collision and i_use in the same cycle in HOLD -> the use is taken and no roulette starts.
- Reset mid-effect: assert i_rst_n=0 on the 3rd cycle of SHIELD ACTIVE -> o_shield=0 and o_state=0 immediately, without waiting for a clock edge. After release the LFSR restarts from 8'hA5.
- With CAR_ITEM_FORCE_EN: i_force_valid=1, i_force_item=2 in EMPTY -> the next cycle has o_state=2, o_item=2. Force in HOLD together with use_edge -> force wins and the item is replaced. i_force_item=0 -> no change.

Source files
------------

// File: rtl/car_item_slot.sv
// Per-car item slot: q-block pickup starts a roulette, the drawn item is held until "use", then applied.
// Optional debug force of the held item is compiled in with `define CAR_ITEM_FORCE_EN.
module car_item_slot #(
   parameter int           FRAME_RATE      = 60,
   parameter int           ROULETTE_FRAMES = 90,
   parameter int           EFFECT_SECONDS  = 3,
   parameter logic [7:0]   LFSR_SEED       = 8'hA5
) (
   input  logic       i_render_clk,
   input  logic       i_rst_n,
   input  logic       i_collision,
   input  logic       i_use,
   output logic [1:0] o_item,
   output logic [1:0] o_state,
   output logic       o_boost,
   output logic       o_shield,
   output logic       o_drop
`ifdef CAR_ITEM_FORCE_EN
   ,
   input  logic       i_force_valid,
   input  logic [1:0] i_force_item
`endif
);

   localparam int FC_MAX = (FRAME_RATE > ROULETTE_FRAMES) ? FRAME_RATE : ROULETTE_FRAMES;
   localparam int FW     = (FC_MAX > 1) ? $clog2(FC_MAX) : 1;
   localparam int SW     = (EFFECT_SECONDS > 0) ? $clog2(EFFECT_SECONDS + 1) : 1;

   localparam logic [FW-1:0] RF_LAST = FW'(ROULETTE_FRAMES - 1);
   localparam logic [FW-1:0] FR_LAST = FW'(FRAME_RATE - 1);
   localparam logic [FW-1:0] F_ONE   = FW'(1);
   localparam logic [SW-1:0] ES_LAST = SW'(EFFECT_SECONDS - 1);
   localparam logic [SW-1:0] S_ONE   = SW'(1);

   localparam logic [1:0] ITEM_NONE   = 2'd0;
   localparam logic [1:0] ITEM_BOOST  = 2'd1;
   localparam logic [1:0] ITEM_SHIELD = 2'd2;
   localparam logic [1:0] ITEM_BANANA = 2'd3;

   typedef enum logic [1:0] {
      ST_EMPTY    = 2'd0,
      ST_ROULETTE = 2'd1,
      ST_HOLD     = 2'd2,
      ST_ACTIVE   = 2'd3
   } state_t;

   state_t        state;
   logic [7:0]    lfsr;
   logic [7:0]    lfsr_next;
   logic [FW-1:0] frame_cnt;
   logic [SW-1:0] sec_cnt;
   logic          use_prev;
   logic          use_edge;
   logic          force_hit;
   logic [1:0]    force_item;

   function automatic logic [1:0] item_map(input logic [7:0] l);
      case (l[1:0])
         2'b10:   item_map = ITEM_SHIELD;
         2'b11:   item_map = ITEM_BANANA;
         default: item_map = ITEM_BOOST;
      endcase
   endfunction

   assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   assign use_edge  = i_use & ~use_prev;
   assign o_state   = state;

`ifdef CAR_ITEM_FORCE_EN
   assign force_hit  = i_force_valid && (i_force_item != ITEM_NONE);
   assign force_item = i_force_item;
`else
   assign force_hit  = 1'b0;
   assign force_item = ITEM_NONE;
`endif

   always_ff @(posedge i_render_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= ST_EMPTY;
         lfsr      <= LFSR_SEED;
         frame_cnt <= '0;
         sec_cnt   <= '0;
         use_prev  <= 1'b0;
         o_item    <= ITEM_NONE;
         o_boost   <= 1'b0;
         o_shield  <= 1'b0;
         o_drop    <= 1'b0;
      end else begin
         lfsr     <= lfsr_next;
         use_prev <= i_use;
         o_drop   <= 1'b0;
         case (state)
            ST_EMPTY: begin
               if (force_hit) begin
                  state  <= ST_HOLD;
                  o_item <= force_item;
               end else if (i_collision) begin
                  state     <= ST_ROULETTE;
                  frame_cnt <= '0;
                  o_item    <= item_map(lfsr_next);
               end
            end
            // o_item is loaded with the map of the LFSR value present in the next cycle,
            // so the last shown value is already the held item when the spin ends.
            ST_ROULETTE: begin
               if (frame_cnt == RF_LAST) begin
                  state     <= ST_HOLD;
                  frame_cnt <= '0;
               end else begin
                  frame_cnt <= frame_cnt + F_ONE;
                  o_item    <= item_map(lfsr_next);
               end
            end
            ST_HOLD: begin
               if (force_hit) begin
                  o_item <= force_item;
               end else if (use_edge) begin
                  if (o_item == ITEM_BANANA) begin
                     state  <= ST_EMPTY;
                     o_item <= ITEM_NONE;
                     o_drop <= 1'b1;
                  end else begin
                     state     <= ST_ACTIVE;
                     frame_cnt <= '0;
                     sec_cnt   <= '0;
                     o_boost   <= (o_item == ITEM_BOOST);
                     o_shield  <= (o_item == ITEM_SHIELD);
                  end
               end
            end
            ST_ACTIVE: begin
               if (frame_cnt == FR_LAST) begin
                  frame_cnt <= '0;
                  if (sec_cnt == ES_LAST) begin
                     state    <= ST_EMPTY;
                     sec_cnt  <= '0;
                     o_item   <= ITEM_NONE;
                     o_boost  <= 1'b0;
                     o_shield <= 1'b0;
                  end else begin
                     sec_cnt <= sec_cnt + S_ONE;
                  end
               end else begin
                  frame_cnt <= frame_cnt + F_ONE;
               end
            end
            default: state <= ST_EMPTY;
         endcase
      end
   end

endmodule
